// File: rtl/alu_pkg.sv
// Shared ALU datapath package.
// Holds the serial-subtractor FSM state encoding (S_IDLE, S_BUSY, S_DONE),
// the default digit width, and the helpers that derive the digit count and
// the digit-index width from WIDTH/DIGIT.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIGIT_DEF   = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int NDIGITS_DEF = WIDTH_DEF / DIGIT_DEF;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of a counter that addresses n digits (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/borrow_lookahead_subtractor_4.sv
// Combinational DIGIT-bit subtractor: diff = x - y - bin, bout = borrow out.
// Every internal borrow is built directly from generate/propagate terms and
// the incoming borrow, so no bit waits on a rippled neighbour.
//
// Ports:
//   x    [DIGIT-1:0]  minuend digit
//   y    [DIGIT-1:0]  subtrahend digit
//   bin               borrow in
//   diff [DIGIT-1:0]  difference digit
//   bout              borrow out of the digit MSB
module borrow_lookahead_subtractor_4
  import alu_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT-1:0] w_gen;
  logic [DIGIT-1:0] w_prop;
  logic [DIGIT:0]   w_bor;

  // A bit generates a borrow when x=0,y=1 and passes one on when x==y.
  assign w_gen  = ~x & y;
  assign w_prop = ~(x ^ y);

  // Borrow into bit i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]bin, flattened.
  always_comb begin
    logic w_term;
    logic w_chain;
    w_bor    = '0;
    w_bor[0] = bin;
    for (int i = 0; i < DIGIT; i++) begin
      w_term  = w_gen[i];
      w_chain = w_prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term  = w_term | (w_chain & w_gen[j]);
        w_chain = w_chain & w_prop[j];
      end
      w_bor[i+1] = w_term | (w_chain & bin);
    end
  end

  assign diff = x ^ y ^ w_bor[DIGIT-1:0];
  assign bout = w_bor[DIGIT];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: res = (a - b) mod 2^WIDTH, one DIGIT-bit
// slice per clock, least significant digit first. One lookahead digit
// subtractor is shared across all digits; the borrow between digits lives
// only in a register, so no combinational path crosses a digit boundary.
//
// Optional build macro NIBBLE_SUB_FLAGS_EN adds registered zero/overflow
// outputs that are valid together with out_valid.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands presented on a/b
//   in_ready   ready to accept operands (IDLE only)
//   a, b       minuend / subtrahend, sampled only on the accept edge
//   out_valid  res/borrow valid (DONE only)
//   out_ready  consumer takes the result
//   res        (a - b) mod 2^WIDTH, registered
//   borrow     1 iff a < b unsigned
//   zero       (flags build) res == 0
//   overflow   (flags build) signed two's-complement overflow
module nibble_serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             borrow
`ifdef NIBBLE_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam int NDIG  = digit_count(WIDTH, DIGIT);
  localparam int IDX_W = idx_bits(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_bor;
  logic             r_borrow;
  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_diff;
  logic             w_bout;
  logic             w_accept;
  logic             w_busy;
  logic             w_last;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_busy   = (r_state == S_BUSY);
  assign w_last   = (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------
  // Operand capture (accept edge only; later a/b changes are ignored)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // ---------------------------------------------------------------------
  // Digit select, shared digit subtractor, result merge
  // ---------------------------------------------------------------------
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_x = r_a[d*DIGIT +: DIGIT];
        w_y = r_b[d*DIGIT +: DIGIT];
      end
    end
  end

  borrow_lookahead_subtractor_4 #(
    .DIGIT (DIGIT)
  ) u_digit_sub (
    .x    (w_x),
    .y    (w_y),
    .bin  (r_bor),
    .diff (w_diff),
    .bout (w_bout)
  );

  // Full result as it will look after this cycle's digit is written.
  always_comb begin
    w_res_next = r_res;
    for (int d = 0; d < NDIG; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_res_next[d*DIGIT +: DIGIT] = w_diff;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit sequencing, borrow chain and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_bor    <= 1'b0;
      r_res    <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_bor <= 1'b0;
    end else if (w_busy) begin
      r_res <= w_res_next;
      r_bor <= w_bout;
      r_idx <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_borrow <= w_bout;
      end
    end
  end

  assign res    = r_res;
  assign borrow = r_borrow;

`ifdef NIBBLE_SUB_FLAGS_EN
  logic r_zero;
  logic r_overflow;

  // Flags are taken from the completed result on the last digit edge, so
  // they change together with res and hold with it through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_busy && w_last) begin
      r_zero     <= (w_res_next == '0);
      r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                    (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign zero     = r_zero;
  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16, DIGIT=4).
// A transaction-level model predicts handshake and result values every
// cycle; directed transactions pin literal results and the 4-cycle latency.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] res;
  logic        borrow;
`ifdef NIBBLE_SUB_FLAGS_EN
  logic        zero;
  logic        overflow;
`endif

  nibble_serial_subtractor #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .borrow    (borrow)
`ifdef NIBBLE_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction model: idle -> counting down 4 cycles -> result held until taken.
  bit          m_idle  = 1'b1;
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  logic [15:0] m_res   = '0;
  logic        m_bor   = 1'b0;
  logic        m_zero  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [15:0] p_res;
  logic        p_bor;
  logic        p_zero;
  logic        p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_left = 0;
      m_res = '0; m_bor = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        int sd;
        sd     = int'($signed(a)) - int'($signed(b));
        p_res  = 16'((int'(a) - int'(b)) & 32'hFFFF);
        p_bor  = (int'(a) < int'(b));
        p_zero = (p_res == 16'h0000);
        p_ovf  = (sd > 32767) || (sd < -32768);
        m_left = 4;
        m_idle = 1'b0;
      end
    end else if (!m_valid) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_res = p_res; m_bor = p_bor; m_zero = p_zero; m_ovf = p_ovf;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end
  end

  // Per-cycle comparison against the model; res/borrow are meaningful
  // whenever the block is not mid-computation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_idle);
      check("out_valid", out_valid, m_valid);
      if (m_idle || m_valid) begin
        check("res", res, m_res);
        check("borrow", borrow, m_bor);
`ifdef NIBBLE_SUB_FLAGS_EN
        check("zero", zero, m_zero);
        check("overflow", overflow, m_ovf);
`endif
      end
    end
  end

  // Present operands until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] ia, input logic [15:0] ib);
    int g;
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Count clock edges from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  // Hold the result for 'hold' cycles (with junk offered on the input), then take it.
  task automatic retire(input int hold);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] er, input logic eb, input int hold);
    int lat;
    send(ia, ib);
    wait_result(lat);
    check({name, "_latency"}, lat, 32'd4);
    check({name, "_res"}, res, er);
    check({name, "_borrow"}, borrow, eb);
    retire(hold);
  endtask

  logic [15:0] edge_vals [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  initial begin
    int          lat;
    logic [15:0] held;
    logic [15:0] ra;
    logic [15:0] rb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 32'd1);
    check("reset_out_valid", out_valid, 32'd0);
    check("reset_res", res, 32'h0);
    check("reset_borrow", borrow, 32'd0);
    rst = 1'b0;

    run("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 0);
    run("ripple", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1);
    run("equal", 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 0);
`ifdef NIBBLE_SUB_FLAGS_EN
    check("equal_zero", zero, 32'd1);
    check("equal_overflow", overflow, 32'd0);
`endif
    send(16'h8000, 16'h0001);
    wait_result(lat);
    check("sovf_latency", lat, 32'd4);
    check("sovf_res", res, 32'h7FFF);
    check("sovf_borrow", borrow, 32'd0);
`ifdef NIBBLE_SUB_FLAGS_EN
    check("sovf_overflow", overflow, 32'd1);
    check("sovf_zero", zero, 32'd0);
`endif
    retire(0);

    // Backpressure: result must hold while new operands are offered.
    send(16'hBEEF, 16'h1234);
    wait_result(lat);
    held = res;
    check("bp_res", held, 32'hACBB);
    for (int h = 0; h < 3; h++) begin
      in_valid = 1'b1; a = 16'h0F0F; b = 16'h0001; out_ready = 1'b0;
      @(negedge clk);
      check("bp_hold_res", res, held);
      check("bp_hold_in_ready", in_ready, 32'd0);
      check("bp_hold_out_valid", out_valid, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_in_ready", in_ready, 32'd1);
    check("bp_after_out_valid", out_valid, 32'd0);

    // Reset asserted during the second BUSY cycle.
    send(16'hABCD, 16'h1111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 32'd1);
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_res", res, 32'h0);
    run("after_rst", 16'h0005, 16'h0003, 16'h0002, 1'b0, 0);

    // Randomized traffic; values checked by the per-cycle model compare.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'($urandom); rb = ra; end
        2: begin
          ra = edge_vals[$urandom_range(0, 4)];
          rb = edge_vals[$urandom_range(0, 4)];
        end
        default: begin ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); end
      endcase
      send(ra, rb);
      wait_result(lat);
      check("rand_latency", lat, 32'd4);
      retire($urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
